// File: rtl/pong_game_state.sv
// pong_game_state: per-frame Pong engine. Holds paddles, ball, scores and the
// serve/play/point/over sequence; everything advances on frame_tick only.
//
// state     | meaning
// SERVE (0) | ball parked at centre while the serve counter runs
// PLAY  (1) | ball moving: wall bounces, paddle hits, misses
// POINT (2) | one frame after a miss: recentre, aim at the conceding side
// OVER  (3) | a score reached SCORE_MAX; frozen until start
module pong_game_state #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int SCORE_MAX    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       start,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] state,
    output logic       game_over
);
    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES);

    // Signed 12-bit working constants so underflow shows up as a sign bit.
    localparam logic signed [11:0] PY_MAX = 12'(V_ACTIVE - PADDLE_H);
    localparam logic signed [11:0] P_SPD  = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] B_SPD  = 12'(BALL_SPEED);
    localparam logic signed [11:0] B_SIZE = 12'(BALL_SIZE);
    localparam logic signed [11:0] P_H    = 12'(PADDLE_H);
    localparam logic signed [11:0] BY_MAX = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] FACE_L = 12'(PADDLE_XL + PADDLE_W);
    localparam logic signed [11:0] FACE_R = 12'(PADDLE_XR);
    localparam logic signed [11:0] MISS_R = 12'(H_ACTIVE - BALL_SIZE);

    localparam logic [9:0]       BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]       PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0]       BALL_YTOP = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]       HIT_XL    = 10'(PADDLE_XL + PADDLE_W);
    localparam logic [9:0]       HIT_XR    = 10'(PADDLE_XR - BALL_SIZE);
    localparam logic [3:0]       SCORE_TOP = 4'(SCORE_MAX);
    localparam logic [CNT_W-1:0] SERVE_END = CNT_W'(SERVE_FRAMES - 1);

    state_t           st_q, st_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             dx_q, dx_n;   // 1 = moving right
    logic             dy_q, dy_n;   // 1 = moving down
    logic [9:0]       pl_n, pr_n, bx_n, by_n;
    logic [3:0]       sl_n, sr_n;

    logic signed [11:0] bx, by, pl, pr, nx, ny;
    logic               ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;

    function automatic logic [9:0] paddle_step(input logic [9:0] y,
                                               input logic up, input logic dn);
        logic signed [11:0] t;
        t = {2'b00, y};
        if (up && !dn) begin
            t = t - P_SPD;
            if (t[11]) t = '0;
        end else if (dn && !up) begin
            t = t + P_SPD;
            if (t > PY_MAX) t = PY_MAX;
        end
        return t[9:0];
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_TOP) ? SCORE_TOP : s + 4'd1;
    endfunction

    assign state     = st_q;
    assign game_over = (st_q == ST_OVER);

    // Next-frame computation; collision tests use the pre-update ball and paddles.
    always_comb begin
        pl_n  = paddle_l_y;
        pr_n  = paddle_r_y;
        bx_n  = ball_x;
        by_n  = ball_y;
        dx_n  = dx_q;
        dy_n  = dy_q;
        sl_n  = score_l;
        sr_n  = score_r;
        st_n  = st_q;
        cnt_n = cnt_q;

        bx = {2'b00, ball_x};
        by = {2'b00, ball_y};
        pl = {2'b00, paddle_l_y};
        pr = {2'b00, paddle_r_y};
        nx = dx_q ? bx + B_SPD : bx - B_SPD;
        ny = dy_q ? by + B_SPD : by - B_SPD;

        ov_l   = (by + B_SIZE > pl) && (by < pl + P_H);
        ov_r   = (by + B_SIZE > pr) && (by < pr + P_H);
        hit_l  = !dx_q && (bx >= FACE_L) && (nx <= FACE_L) && ov_l;
        hit_r  = dx_q && (bx + B_SIZE <= FACE_R) && (nx + B_SIZE >= FACE_R) && ov_r;
        miss_l = !dx_q && !hit_l && (nx[11] || nx == '0);
        miss_r = dx_q && !hit_r && (nx >= MISS_R);

        if (frame_tick) begin
            if (st_q != ST_OVER) begin
                pl_n = paddle_step(paddle_l_y, btn_l_up, btn_l_dn);
                pr_n = paddle_step(paddle_r_y, btn_r_up, btn_r_dn);
            end
            case (st_q)
                ST_SERVE: begin
                    bx_n = BALL_X0;
                    by_n = BALL_Y0;
                    if (cnt_q == SERVE_END) begin
                        cnt_n = '0;
                        st_n  = ST_PLAY;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (ny[11]) begin
                        by_n = '0;
                        dy_n = 1'b1;
                    end else if (ny >= BY_MAX) begin
                        by_n = BALL_YTOP;
                        dy_n = 1'b0;
                    end else begin
                        by_n = ny[9:0];
                    end
                    if (hit_l) begin
                        bx_n = HIT_XL;
                        dx_n = 1'b1;
                    end else if (hit_r) begin
                        bx_n = HIT_XR;
                        dx_n = 1'b0;
                    end else begin
                        bx_n = nx[11] ? '0 : nx[9:0];
                        if (miss_l) begin
                            sr_n = score_inc(score_r);
                            st_n = ST_POINT;
                        end else if (miss_r) begin
                            sl_n = score_inc(score_l);
                            st_n = ST_POINT;
                        end
                    end
                end
                ST_POINT: begin
                    // dx was left untouched by the miss, so it already points
                    // at the player who conceded.
                    bx_n = BALL_X0;
                    by_n = BALL_Y0;
                    st_n = (score_l == SCORE_TOP || score_r == SCORE_TOP) ? ST_OVER : ST_SERVE;
                end
                ST_OVER: begin
                    if (start) begin
                        sl_n  = '0;
                        sr_n  = '0;
                        bx_n  = BALL_X0;
                        by_n  = BALL_Y0;
                        cnt_n = '0;
                        st_n  = ST_SERVE;
                    end
                end
            endcase
        end
    end

    // Game state registers; reset wins over frame_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddle_l_y <= PADDLE_Y0;
            paddle_r_y <= PADDLE_Y0;
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            score_l    <= '0;
            score_r    <= '0;
            st_q       <= ST_SERVE;
            cnt_q      <= '0;
        end else begin
            paddle_l_y <= pl_n;
            paddle_r_y <= pr_n;
            ball_x     <= bx_n;
            ball_y     <= by_n;
            dx_q       <= dx_n;
            dy_q       <= dy_n;
            score_l    <= sl_n;
            score_r    <= sr_n;
            st_q       <= st_n;
            cnt_q      <= cnt_n;
        end
    end
endmodule
